// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam logic [31:0] MEM_BASE = 32'h0100_0000;
    localparam int          INSN_W   = 32;
    localparam logic [31:0] PC_STEP  = 32'd4;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    typedef struct packed {
        logic [31:0]       pc;
        logic [INSN_W-1:0] insn;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-stage bus bundle: imem request/response, decode handshake and redirect.
interface fetch_queue_if;
    import fetch_pkg::*;

    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [31:0]       mem_req_addr;
    logic              mem_resp_valid;
    logic [INSN_W-1:0] mem_resp_data;
    logic              insn_valid;
    logic              insn_ready;
    logic [INSN_W-1:0] insn;
    logic [31:0]       insn_pc;
    logic              redirect_valid;
    logic [31:0]       redirect_pc;

    modport master (
        output mem_req_valid, mem_req_addr, insn_valid, insn, insn_pc,
        input  mem_req_ready, mem_resp_valid, mem_resp_data, insn_ready,
               redirect_valid, redirect_pc
    );

    modport slave (
        input  mem_req_valid, mem_req_addr, insn_valid, insn, insn_pc,
        output mem_req_ready, mem_resp_valid, mem_resp_data, insn_ready,
               redirect_valid, redirect_pc
    );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous flush; head data reads as zero when empty.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    input  logic                   flush,
    output logic [$clog2(DEPTH):0] count,
    output logic [WIDTH-1:0]       head_data
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_pop;

    assign do_pop    = pop && (count != '0);
    assign head_data = (count != '0) ? mem[rd_ptr] : '0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            assert (!(push && !do_pop && count == CW'(DEPTH)));
            if (push)   wr_ptr <= wr_ptr + AW'(1);
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(do_pop);
        end
    end

    // Storage needs no reset: head_data is masked while count is zero.
    always_ff @(posedge clock) begin
        if (push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch stage: sequential imem requests under a credit cap, response
// buffering with PCs, and redirect flush that drops stale in-flight responses.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = MEM_BASE,
    parameter int          DEPTH    = 4
) (
    input logic           clock,
    input logic           reset,
    fetch_queue_if.master bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]  fetch_pc;
    logic [31:0]  resp_pc;
    logic [31:0]  target_pc;
    logic [CW-1:0] count;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop_cnt;
    logic [CW:0]   credit_used;
    logic          req_fire;
    logic          dropping;
    logic          push;
    logic          pop;
    fetch_entry_t  push_entry;
    fetch_entry_t  head_entry;
    logic [$bits(fetch_entry_t)-1:0] head_data;

    // Entries plus in-flight requests never exceed DEPTH, so a push always fits.
    assign credit_used       = {1'b0, count} + {1'b0, outstanding};
    assign bus.mem_req_valid = !reset && !bus.redirect_valid
                               && (credit_used < (CW+1)'(DEPTH));
    assign bus.mem_req_addr  = fetch_pc;
    assign req_fire          = bus.mem_req_valid && bus.mem_req_ready;

    assign dropping   = (drop_cnt != '0);
    assign push       = bus.mem_resp_valid && !bus.redirect_valid && !dropping;
    assign pop        = bus.insn_valid && bus.insn_ready;
    assign push_entry = '{pc: resp_pc, insn: bus.mem_resp_data};
    assign target_pc  = {bus.redirect_pc[31:2], 2'b00};

    assign head_entry     = fetch_entry_t'(head_data);
    assign bus.insn_valid = (count != '0);
    assign bus.insn       = head_entry.insn;
    assign bus.insn_pc    = head_entry.pc;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            assert (!(bus.mem_resp_valid && outstanding == '0));
            if (bus.redirect_valid) begin
                // Everything still in flight after this cycle belongs to the old path.
                fetch_pc    <= target_pc;
                resp_pc     <= target_pc;
                outstanding <= outstanding - CW'(bus.mem_resp_valid);
                drop_cnt    <= outstanding - CW'(bus.mem_resp_valid);
            end else begin
                if (req_fire) fetch_pc <= fetch_pc + PC_STEP;
                if (push)     resp_pc  <= resp_pc + PC_STEP;
                outstanding <= outstanding + CW'(req_fire) - CW'(bus.mem_resp_valid);
                if (bus.mem_resp_valid && dropping) drop_cnt <= drop_cnt - CW'(1);
            end
        end
    end

    sync_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (bus.redirect_valid),
        .count     (count),
        .head_data (head_data)
    );

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: random imem/decode/redirect traffic against a queue-based model.
module tb_fetch_queue;
    import fetch_pkg::*;

    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] addr;
        logic        drop;
        int          due;
    } infl_t;

    logic clock = 1'b0;
    logic reset;

    fetch_queue_if bus ();

    fetch_queue #(.RESET_PC(MEM_BASE), .DEPTH(DEPTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int pops  = 0;
    int p_rdy, p_irdy, p_resp, p_redir, lat;
    logic        f_rd;
    logic [31:0] f_rpc;
    logic [31:0] req_pc;
    fetch_entry_t fq[$];
    infl_t        inflight[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ NOP;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic set_knobs(input int rdy, input int irdy, input int resp, input int redir, input int l);
        p_rdy = rdy; p_irdy = irdy; p_resp = resp; p_redir = redir; lat = l;
    endtask

    // One clock: drive, compare against the model, advance the model, pass the edge.
    task automatic step();
        logic rdy, ird, rd, rv, exp_rv;
        logic [31:0] rpc;
        infl_t e;
        @(negedge clock);
        rdy = ($urandom_range(99) < p_rdy);
        ird = ($urandom_range(99) < p_irdy);
        rd  = f_rd || ($urandom_range(99) < p_redir);
        if (f_rd)                    rpc = f_rpc;
        else if ($urandom_range(1)) rpc = $urandom();
        else                         rpc = MEM_BASE + 32'($urandom_range(4095));
        rv = (inflight.size() != 0) && (inflight[0].due <= cyc) && ($urandom_range(99) < p_resp);
        bus.mem_req_ready  = rdy;
        bus.insn_ready     = ird;
        bus.redirect_valid = rd;
        bus.redirect_pc    = rpc;
        bus.mem_resp_valid = rv;
        bus.mem_resp_data  = rv ? mem_word(inflight[0].addr) : $urandom();
        #1;
        exp_rv = !rd && ((fq.size() + inflight.size()) < DEPTH);
        chk("req_valid", bus.mem_req_valid, exp_rv);
        chk("req_addr", bus.mem_req_addr, req_pc);
        chk("insn_valid", bus.insn_valid, fq.size() != 0);
        chk("insn", bus.insn, (fq.size() != 0) ? fq[0].insn : 32'h0);
        chk("insn_pc", bus.insn_pc, (fq.size() != 0) ? fq[0].pc : 32'h0);
        if (fq.size() != 0 && ird) begin
            void'(fq.pop_front());
            pops++;
        end
        if (rv) begin
            e = inflight.pop_front();
            if (!e.drop && !rd) fq.push_back('{pc: e.addr, insn: mem_word(e.addr)});
        end
        if (exp_rv && rdy) begin
            inflight.push_back('{addr: req_pc, drop: 1'b0, due: cyc + 1 + int'($urandom_range(lat))});
            req_pc += 32'd4;
        end
        if (rd) begin
            fq.delete();
            foreach (inflight[i]) inflight[i].drop = 1'b1;
            req_pc = {rpc[31:2], 2'b00};
        end
        cyc++;
        @(posedge clock);
        #1;
    endtask

    task automatic wait_valid(input int lim);
        int n;
        n = 0;
        while (bus.insn_valid !== 1'b1 && n < lim) begin
            step();
            n++;
        end
        chk("wait_valid_timeout", 32'(n < lim), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_valid"}, bus.mem_req_valid, 1'b0);
        chk({tag, "_req_addr"}, bus.mem_req_addr, MEM_BASE);
        chk({tag, "_insn_valid"}, bus.insn_valid, 1'b0);
        chk({tag, "_insn"}, bus.insn, 32'h0);
        chk({tag, "_insn_pc"}, bus.insn_pc, 32'h0);
    endtask

    task automatic idle_inputs();
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = 32'h0;
        bus.insn_ready     = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
    endtask

    initial begin
        reset = 1'b1;
        f_rd = 1'b0;
        f_rpc = 32'h0;
        req_pc = MEM_BASE;
        idle_inputs();
        set_knobs(100, 100, 100, 0, 0);
        #1;
        check_reset_outputs("rst");
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("first_req_valid", bus.mem_req_valid, 1'b1);
        chk("first_req_addr", bus.mem_req_addr, 32'h0100_0000);

        // Single-cycle memory, decode always ready: one instruction per clock.
        repeat (6) step();
        begin
            int p0;
            p0 = pops;
            repeat (10) step();
            chk("steady_rate", 32'(pops - p0), 32'd10);
        end

        // Decode stalled: queue fills to DEPTH and requests stop.
        set_knobs(100, 0, 100, 0, 0);
        repeat (10) step();
        chk("bp_count", 32'(dut.u_fifo.count), 32'd4);
        chk("bp_req_valid", bus.mem_req_valid, 1'b0);
        set_knobs(100, 100, 100, 0, 0);
        repeat (12) step();

        // Three requests in flight, then redirect.
        set_knobs(0, 100, 100, 0, 0);
        repeat (8) step();
        set_knobs(100, 100, 0, 0, 0);
        repeat (3) step();
        chk("infl3_outstanding", 32'(dut.outstanding), 32'd3);
        f_rd = 1'b1; f_rpc = 32'h0100_0100;
        step();
        f_rd = 1'b0;
        chk("redir_addr", bus.mem_req_addr, 32'h0100_0100);
        chk("redir_drop_cnt", 32'(dut.drop_cnt), 32'd3);
        set_knobs(100, 0, 100, 0, 0);
        wait_valid(40);
        chk("redir_first_pc", bus.insn_pc, 32'h0100_0100);

        // Redirect coinciding with a response while two are outstanding.
        set_knobs(0, 100, 100, 0, 0);
        repeat (8) step();
        set_knobs(100, 100, 0, 0, 0);
        repeat (2) step();
        set_knobs(0, 100, 100, 0, 0);
        f_rd = 1'b1; f_rpc = 32'h0100_0200;
        step();
        f_rd = 1'b0;
        chk("same_cycle_drop_cnt", 32'(dut.drop_cnt), 32'd1);
        set_knobs(100, 0, 100, 0, 0);
        wait_valid(40);
        chk("same_cycle_first_pc", bus.insn_pc, 32'h0100_0200);

        // Misaligned target, then imem stalls requests.
        set_knobs(0, 100, 100, 0, 0);
        f_rd = 1'b1; f_rpc = 32'h0100_0102;
        step();
        f_rd = 1'b0;
        chk("align_addr", bus.mem_req_addr, 32'h0100_0100);
        repeat (5) step();
        chk("stall_addr", bus.mem_req_addr, 32'h0100_0100);
        chk("stall_fetch_pc", dut.fetch_pc, 32'h0100_0100);

        // Random traffic with variable latency and occasional redirects.
        begin
            int p0;
            p0 = pops;
            set_knobs(70, 60, 75, 3, 3);
            repeat (600) step();
            chk("rand_progress", 32'((pops - p0) > 100), 32'd1);
        end

        // Async reset with entries queued and requests in flight.
        set_knobs(100, 0, 100, 0, 0);
        repeat (3) step();
        set_knobs(100, 0, 0, 0, 0);
        repeat (2) step();
        chk("pre_rst_valid", bus.insn_valid, fq.size() != 0);
        chk("pre_rst_outstanding", 32'(dut.outstanding), 32'(inflight.size()));
        reset = 1'b1;
        idle_inputs();
        #1;
        check_reset_outputs("midrst");
        fq.delete();
        inflight.delete();
        req_pc = MEM_BASE;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("post_rst_addr", bus.mem_req_addr, 32'h0100_0000);
        set_knobs(80, 80, 80, 0, 2);
        repeat (40) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
